// File: rtl/display_scan_ctrl_pkg.sv
// Shared display constants and scan-state encoding.
// The scan state value is also the digit index seen by the seven-segment driver.
package display_scan_ctrl_pkg;
   localparam int NUM_DIGITS       = 4;
   localparam int NIBBLE_W         = 4;
   localparam int DATA_W           = NUM_DIGITS * NIBBLE_W;
   localparam int SEL_W            = $clog2(NUM_DIGITS);
   localparam int TICK_DIV_DEFAULT = 100000;

   typedef enum logic [SEL_W-1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } scan_state_t;
endpackage

// File: rtl/display_scan_ctrl_tick_gen.sv
// Digit-slot divider: a free-running count 0..TICK_DIV-1.
// tick is high in the last cycle of each slot.
module tick_gen #(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] tick_cnt;

   assign tick = (tick_cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + CNT_W'(1);
   end
endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit display scanner with frame-synchronous value commit.
// result only changes on the DIG3->DIG0 boundary, so a frame never shows two values.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] value_in,
   input  logic              value_valid,
   input  logic              hold,
   output logic [DATA_W-1:0] result,
   output logic [SEL_W-1:0]  digitSelect,
   output logic              frame_start,
   output logic              update_ack
);
   logic              tick;
   logic              commit_edge;
   scan_state_t       state, state_nxt;
   logic [DATA_W-1:0] pending;
   logic              pending_flag;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= DIG0;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      commit_edge = 1'b0;
      if (tick) begin
         case (state)
            DIG0:    state_nxt = DIG1;
            DIG1:    state_nxt = DIG2;
            DIG2:    state_nxt = DIG3;
            DIG3: begin
               state_nxt   = DIG0;
               commit_edge = 1'b1;
            end
            default: state_nxt = DIG0;
         endcase
      end
   end

   assign digitSelect = state;

   // A value arriving on the commit edge bypasses pending; while held, it still queues.
   always_ff @(posedge clk) begin
      if (rst) begin
         result       <= '0;
         pending      <= '0;
         pending_flag <= 1'b0;
         frame_start  <= 1'b0;
         update_ack   <= 1'b0;
      end else begin
         frame_start <= commit_edge;
         update_ack  <= 1'b0;
         if (commit_edge && !hold) begin
            if (value_valid) begin
               result       <= value_in;
               pending_flag <= 1'b0;
               update_ack   <= 1'b1;
            end else if (pending_flag) begin
               result       <= pending;
               pending_flag <= 1'b0;
               update_ack   <= 1'b1;
            end
         end else if (value_valid) begin
            pending      <= value_in;
            pending_flag <= 1'b1;
         end
      end
   end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port value_in, input, 16, new 4-nibble value to display.
REQ-005 SHALL have port value_valid, input, 1, value_in is valid this cycle.
REQ-006 SHALL have port hold, input, 1, suppresses commit of pending values while high.
REQ-007 SHALL have port result, output, 16, committed display value, registered; drives sevenSeg result.
REQ-008 SHALL have port digitSelect, output, 2, active digit index, registered; drives sevenSeg digitSelect.
REQ-009 SHALL have port frame_start, output, 1, one-cycle pulse on digitSelect 3->0 transition.
REQ-010 SHALL have port update_ack, output, 1, one-cycle pulse in the first cycle result shows a newly committed value.

Function
REQ-011 SHALL count tick_cnt 0..TICK_DIV-1, wrapping to 0; tick is asserted in the cycle where tick_cnt == TICK_DIV-1.
REQ-012 SHALL advance digitSelect on tick: 0->1->2->3->0; new index visible the cycle after tick.
REQ-013 SHALL model scan as 4-state FSM (DIG0..DIG3) with digitSelect as state encoding; no other transitions.
REQ-014 SHALL assert frame_start in the cycle digitSelect first reads 0 after 3; never after reset alone.
REQ-015 SHALL capture value_in into pending register and set pending_flag on every cycle value_valid is high; later captures overwrite (latest wins).
REQ-016 SHALL commit on the tick edge that moves digitSelect 3->0: if pending_flag and hold low, result <= pending, pending_flag cleared.
REQ-017 SHALL, when value_valid is high on that commit edge and hold low, commit value_in directly and leave pending_flag clear.
REQ-018 SHALL, when hold is high at the commit edge, keep result and pending_flag unchanged; commit occurs at the next frame boundary with hold low.
REQ-019 SHALL never change result except at a 3->0 boundary or reset (no mid-frame tearing).
REQ-020 SHALL assert update_ack in the same cycle result first holds the committed value (coincident with frame_start).
REQ-021 SHALL keep scanning (counter, digitSelect) independent of value_valid and hold.

Reset
REQ-022 SHALL on rst=1 at a clk edge set tick_cnt=0, digitSelect=0, result=16'h0000, pending=0, pending_flag=0, frame_start=0, update_ack=0.
REQ-023 SHALL give rst priority over value_valid, tick and commit in the same cycle; a value presented during reset is discarded.
REQ-024 SHALL resume scanning from DIG0 with a full TICK_DIV slot the first cycle after rst falls.

Structure
REQ-025 SHALL place the digit-count constant (4), nibble width (4) and default TICK_DIV in a shared display package used with sevenSeg.
REQ-026 SHALL implement the tick divider as one sub-module, tick_gen (parameter TICK_DIV, ports clk, rst, tick).
REQ-027 SHALL be sized for 120-400 lines of RTL; no combinational path from inputs to outputs.

Verification (TICK_DIV=4, 16-cycle frame)
REQ-028 SHALL verify reset: rst high 3 cycles -> all outputs 0; digitSelect 0,0,0,0,1,1,1,1,2... from release.
REQ-029 SHALL verify mid-frame update: value_valid with 16'hBEEF while digitSelect=1 -> result stays 0 until 3->0 edge, then 16'hBEEF with frame_start=update_ack=1 for one cycle.
REQ-030 SHALL verify latest-wins: 16'h1234 then 16'h5678 in the same frame -> only 16'h5678 committed, single update_ack.
REQ-031 SHALL verify simultaneous event: value_valid 16'hA5A5 exactly on the commit edge with pending 16'h1111 -> result 16'hA5A5, pending_flag clear.
REQ-032 SHALL verify hold: hold=1 across two boundaries with pending 16'h00FF -> result unchanged, no update_ack; hold=0 -> 16'h00FF at next boundary.
REQ-033 SHALL verify reset mid-operation: rst during digitSelect=2 with pending 16'hC0DE -> result 0, pending discarded, no commit at next boundary.
